// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display path.
// Used by the binary-to-BCD converter and its digit corrector.
package ssd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'h9;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    // Largest value representable in n decimal digits (10^n - 1).
    function automatic longint unsigned max_dec(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_if.sv
// Start/busy/done handshake and result bundle for bin_to_bcd.
// The master requests conversions, the slave performs them.
interface bin_to_bcd_if
    import ssd_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 14
);

    logic                 start;
    logic [W-1:0]         value;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic [N*DIGIT_W-1:0] numbers;

    modport master (
        output start, value,
        input  busy, done, overflow, numbers
    );

    modport slave (
        input  start, value,
        output busy, done, overflow, numbers
    );

endinterface

// File: rtl/bin_to_bcd_add3.sv
// One-digit double-dabble corrector.
// Digits of five or more get three added before the next shift.
module bcd_add3
    import ssd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential shift-and-add-3 binary to packed BCD converter.
// Result is held steady between conversions for the display mux.
module bin_to_bcd
    import ssd_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    bin_to_bcd_if.slave  bus
);

    localparam int SW = N * DIGIT_W;
    localparam int CW = $clog2(W + 1);
    localparam longint unsigned MAXV = max_dec(N);

    state_t        state, state_d;
    logic [SW-1:0] scr, scr_d;
    logic [SW-1:0] corr;
    logic [SW-1:0] nines;
    logic [W-1:0]  bin, bin_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          ovf_pend, ovf_pend_d;
    logic [SW-1:0] num_q, num_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          val_ovf;
    logic [SW+W-1:0] shifted;

    for (genvar g = 0; g < N; g++) begin : g_dig
        bcd_add3 u_add3 (
            .din  (scr[g*DIGIT_W +: DIGIT_W]),
            .dout (corr[g*DIGIT_W +: DIGIT_W])
        );
        assign nines[g*DIGIT_W +: DIGIT_W] = BCD_NINE;
    end

    assign shifted = {corr, bin} << 1;
    assign val_ovf = 64'(bus.value) > MAXV;

    assign bus.busy     = (state == CONVERT);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.numbers  = num_q;

    // Next-state, datapath and commit decisions.
    always_comb begin
        state_d    = state;
        scr_d      = scr;
        bin_d      = bin;
        cnt_d      = cnt;
        ovf_pend_d = ovf_pend;
        num_d      = num_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d    = CONVERT;
                    bin_d      = bus.value;
                    scr_d      = '0;
                    cnt_d      = CW'(W);
                    ovf_pend_d = val_ovf;
                end
            end
            CONVERT: begin
                scr_d = shifted[SW+W-1 -: SW];
                bin_d = shifted[W-1:0];
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_d = IDLE;
                    num_d   = ovf_pend ? nines : shifted[SW+W-1 -: SW];
                    ovf_d   = ovf_pend;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // State, scratch and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            scr      <= '0;
            bin      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            num_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            scr      <= scr_d;
            bin      <= bin_d;
            cnt      <= cnt_d;
            ovf_pend <= ovf_pend_d;
            num_q    <= num_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed and random checks for bin_to_bcd.
// Expected digits come from hand values or a decimal model.
module tb_bin_to_bcd;

    localparam int N = 4;
    localparam int W = 14;

    logic clk;
    logic rst;

    int n_assert;
    int n_fail;

    bin_to_bcd_if #(.N(N), .W(W)) bus ();

    bin_to_bcd #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input int v);
        logic [15:0] r;
        if (v > 9999) return 16'h9999;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic run(input logic [13:0] v,
                       input logic [15:0] en,
                       input logic eo,
                       input string tag);
        int nb;
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.start = 1'b0;
        bus.value = ~v;
        nb = 0;
        cyc = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) nb++;
            cyc++;
            @(negedge clk);
        end
        chk({tag, " timeout"}, 64'(bus.done), 64'd1);
        chk({tag, " busy_cycles"}, 64'(nb), 64'(W));
        chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, " numbers"}, 64'(bus.numbers), 64'(en));
        chk({tag, " overflow"}, 64'(bus.overflow), 64'(eo));
        @(negedge clk);
        chk({tag, " done_1cyc"}, 64'(bus.done), 64'd0);
        chk({tag, " hold"}, 64'(bus.numbers), 64'(en));
    endtask

    initial begin
        int cyc;
        int dcount;
        int v;
        logic [13:0] vals [4];
        logic [15:0] exps [4];

        n_assert = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle numbers", 64'(bus.numbers), 64'h0000);
            chk("idle busy", 64'(bus.busy), 64'd0);
            chk("idle done", 64'(bus.done), 64'd0);
            chk("idle overflow", 64'(bus.overflow), 64'd0);
        end

        run(14'd1234, 16'h1234, 1'b0, "v1234");
        run(14'd9999, 16'h9999, 1'b0, "v9999");
        run(14'd10000, 16'h9999, 1'b1, "v10000");
        run(14'h3FFF, 16'h9999, 1'b1, "v3fff");
        run(14'd0, 16'h0000, 1'b0, "v0");

        vals[0] = 14'd0;  exps[0] = 16'h0000;
        vals[1] = 14'd7;  exps[1] = 16'h0007;
        vals[2] = 14'd10; exps[2] = 16'h0010;
        vals[3] = 14'd99; exps[3] = 16'h0099;
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = vals[0];
        @(negedge clk);
        bus.value = 14'h3FFF;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            while (!bus.done && cyc < 40) begin
                cyc++;
                @(negedge clk);
            end
            chk("b2b timeout", 64'(bus.done), 64'd1);
            chk("b2b numbers", 64'(bus.numbers), 64'(exps[i]));
            chk("b2b overflow", 64'(bus.overflow), 64'd0);
            if (i > 0) chk("b2b period", 64'(cyc), 64'd15);
            if (i < 3) bus.value = vals[i+1];
            else bus.start = 1'b0;
            @(negedge clk);
            bus.value = 14'h3FFF;
            cyc = 1;
        end
        @(negedge clk);
        chk("b2b stopped", 64'(bus.busy), 64'd0);

        run(14'd42, 16'h0042, 1'b0, "v42");
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 14'd4321;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst numbers", 64'(bus.numbers), 64'h0000);
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst overflow", 64'(bus.overflow), 64'd0);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcount++;
        end
        chk("rst no_done", 64'(dcount), 64'd0);
        chk("rst hold", 64'(bus.numbers), 64'h0000);

        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(0, 16383));
            run(14'(v), model(v), v > 9999, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
